// File: rtl/instr_fetch_unit_if.sv
// Instruction delivery channel between the fetch stage and the execute stage,
// plus the redirect path the execute stage uses to steer the program counter.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 5
);
    // ir_valid/ir_ready: ir is transferred on a rising edge where both are high.
    // Once ir_valid rises, ir and ir_pc stay frozen until that edge; the producer
    // may withdraw ir_valid only on a redirect (pc_load) or reset.
    logic [31:0]       ir;
    logic              ir_valid;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_ready;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;

    modport master (
        output ir,
        output ir_valid,
        output ir_pc,
        input  ir_ready,
        input  pc_load,
        input  pc_target
    );

    modport slave (
        input  ir,
        input  ir_valid,
        input  ir_pc,
        output ir_ready,
        output pc_load,
        output pc_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: internal instruction RAM, program counter sequencing, one
// instruction at a time to execute over valid/ready, PC redirect and HALT stop.
module instr_fetch_unit #(
    parameter int          ADDR_W  = 5,
    parameter logic [4:0]  HALT_OP = 5'b11111
) (
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic                 prog_we,
    input  logic [ADDR_W-1:0]    prog_addr,
    input  logic [31:0]          prog_data,
    instr_fetch_unit_if.master   ir_bus,
    output logic                 busy,
    output logic                 halted,
    output logic [1:0]           state_dbg
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir_q;
    logic              ir_valid_q;
    logic [ADDR_W-1:0] ir_pc_q;
    logic              prog_ok;
    logic              handshake;
    logic              ir_is_halt;

    logic [31:0] mem [DEPTH];

    assign prog_ok    = (state == S_IDLE) || (state == S_HALT);
    assign handshake  = ir_valid_q && ir_bus.ir_ready;
    assign ir_is_halt = (ir_q[31:27] == HALT_OP);

    // Program RAM is not touched by reset, so a program survives sys_rst.
    always_ff @(posedge clk) begin
        if (prog_we && prog_ok) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            ir_pc_q    <= '0;
            busy       <= 1'b0;
            halted     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc     <= '0;
                        state  <= S_FETCH;
                        busy   <= 1'b1;
                        halted <= 1'b0;
                    end
                end

                S_FETCH: begin
                    // A redirect here drops the read of the old pc and refetches.
                    if (ir_bus.pc_load) begin
                        pc <= ir_bus.pc_target;
                    end else begin
                        ir_q       <= mem[pc];
                        ir_pc_q    <= pc;
                        ir_valid_q <= 1'b1;
                        pc         <= pc + 1'b1;
                        state      <= S_HOLD;
                    end
                end

                S_HOLD: begin
                    // pc_load outranks the handshake, even when ir is a HALT.
                    if (ir_bus.pc_load) begin
                        pc         <= ir_bus.pc_target;
                        ir_valid_q <= 1'b0;
                        state      <= S_FETCH;
                    end else if (handshake) begin
                        ir_valid_q <= 1'b0;
                        if (ir_is_halt) begin
                            state  <= S_HALT;
                            busy   <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state  <= S_FETCH;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ir_bus.ir       = ir_q;
    assign ir_bus.ir_valid = ir_valid_q;
    assign ir_bus.ir_pc    = ir_pc_q;
    assign state_dbg       = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed/randomized bench for instr_fetch_unit: a reference program image
// and an expected instruction trace derived from sequential-PC/HALT rules.
module tb_instr_fetch_unit;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int EW     = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              start = 1'b0;
  logic              prog_we = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [31:0]       prog_data = '0;
  logic              busy;
  logic              halted;
  logic [1:0]        state_dbg;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) ir_bus();

  instr_fetch_unit #(.ADDR_W(ADDR_W), .HALT_OP(5'b11111)) dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .ir_bus    (ir_bus),
    .busy      (busy),
    .halted    (halted),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0]   ref_mem [DEPTH];
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_halt(input logic [31:0] w);
    return w[31:27] == 5'b11111;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:27] == 5'b11111) w[31:27] = 5'b01110;
    return w;
  endfunction

  // driver tasks
  task automatic prog_write(input int a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a[ADDR_W-1:0];
    prog_data = d;
    step();
    prog_we   = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic load_random(input int halt_at);
    logic [31:0] w;
    for (int a = 0; a < DEPTH; a++) begin
      w = rand_word();
      if (a == halt_at) w[31:27] = 5'b11111;
      prog_write(a, w);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_valid", ir_bus.ir_valid, 0);
    check("start_halted", halted, 0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    check("rst_valid", ir_bus.ir_valid, 0);
    check("rst_busy", busy, 0);
  endtask

  // reference model: sequential PC from first_pc, wrapping, stopping at HALT
  task automatic build_trace(input int first_pc, input int max_n);
    int p;
    p = first_pc;
    exp_q.delete();
    for (int i = 0; i < max_n; i++) begin
      exp_q.push_back({p[ADDR_W-1:0], ref_mem[p]});
      if (is_halt(ref_mem[p])) break;
      p = (p + 1) % DEPTH;
    end
  endtask

  // scoreboard: each queued entry must be presented 1 edge after FETCH,
  // held stable under backpressure, and retired on the handshake edge
  task automatic run_trace(input int bp, input bit in_hold);
    logic [EW-1:0] e;
    int hold;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!in_hold) step();
      in_hold = 1'b0;
      check("pres_valid", ir_bus.ir_valid, 1);
      check("pres_ir_pc", ir_bus.ir_pc, e[EW-1:32]);
      check("pres_ir", ir_bus.ir, e[31:0]);
      check("pres_busy", busy, 1);
      hold = (bp < 0) ? $urandom_range(0, 3) : bp;
      for (int h = 0; h < hold; h++) begin
        ir_bus.ir_ready = 1'b0;
        step();
        check("hold_ir", ir_bus.ir, e[31:0]);
        check("hold_ir_pc", ir_bus.ir_pc, e[EW-1:32]);
        check("hold_valid", ir_bus.ir_valid, 1);
      end
      ir_bus.ir_ready = 1'b1;
      step();
      ir_bus.ir_ready = 1'b0;
      check("acc_valid", ir_bus.ir_valid, 0);
      check("acc_halted", halted, is_halt(e[31:0]));
      check("acc_busy", busy, !is_halt(e[31:0]));
    end
  endtask

  initial begin
    ir_bus.ir_ready  = 1'b0;
    ir_bus.pc_load   = 1'b0;
    ir_bus.pc_target = '0;

    // reset state
    step();
    step();
    sys_rst = 1'b0;
    check("reset_ir", ir_bus.ir, 0);
    check("reset_ir_pc", ir_bus.ir_pc, 0);
    check("reset_valid", ir_bus.ir_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_halted", halted, 0);

    // ADDI then HALT
    prog_write(0, {5'b00010, 5'd0, 5'd2, 17'd4});
    prog_write(1, {5'b11111, 27'd0});
    do_start();
    build_trace(0, 4);
    run_trace(0, 1'b0);

    // redirect while halted is ignored
    ir_bus.pc_load   = 1'b1;
    ir_bus.pc_target = 5'd5;
    step();
    ir_bus.pc_load   = 1'b0;
    check("halt_pcload_halted", halted, 1);
    check("halt_pcload_busy", busy, 0);
    check("halt_pcload_valid", ir_bus.ir_valid, 0);

    // random programs; first round uses 5-cycle backpressure per instruction
    for (int r = 0; r < 3; r++) begin
      load_random($urandom_range(3, 12));
      do_start();
      build_trace(0, DEPTH);
      run_trace((r == 0) ? 5 : -1, 1'b0);
    end

    // redirect from HOLD with ready low
    load_random(-1);
    do_start();
    step();
    check("pre_redir_ir_pc", ir_bus.ir_pc, 0);
    ir_bus.pc_load   = 1'b1;
    ir_bus.pc_target = 5'd7;
    step();
    ir_bus.pc_load   = 1'b0;
    check("redir_valid", ir_bus.ir_valid, 0);
    check("redir_busy", busy, 1);
    build_trace(7, 3);
    run_trace(0, 1'b0);

    // redirect during FETCH
    ir_bus.pc_load   = 1'b1;
    ir_bus.pc_target = 5'd20;
    step();
    ir_bus.pc_load   = 1'b0;
    check("fredir_valid", ir_bus.ir_valid, 0);
    build_trace(20, 3);
    run_trace(-1, 1'b0);

    // asynchronous reset between edges while an instruction is held
    step();
    check("pre_rst_valid", ir_bus.ir_valid, 1);
    #3;
    sys_rst = 1'b1;
    #1;
    check("async_rst_valid", ir_bus.ir_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ir", ir_bus.ir, 0);
    check("async_rst_ir_pc", ir_bus.ir_pc, 0);
    step();
    sys_rst = 1'b0;

    // RAM retained; full walk wraps 31 -> 0
    do_start();
    build_trace(0, DEPTH + 2);
    run_trace(0, 1'b0);

    // HALT accepted together with pc_load does not halt
    do_reset();
    prog_write(5, {5'b11111, 27'h123});
    do_start();
    build_trace(0, 5);
    run_trace(-1, 1'b0);
    step();
    check("halt_pres_ir", ir_bus.ir, ref_mem[5]);
    ir_bus.ir_ready  = 1'b1;
    ir_bus.pc_load   = 1'b1;
    ir_bus.pc_target = 5'd2;
    step();
    ir_bus.ir_ready  = 1'b0;
    ir_bus.pc_load   = 1'b0;
    check("haltld_halted", halted, 0);
    check("haltld_busy", busy, 1);
    check("haltld_valid", ir_bus.ir_valid, 0);
    build_trace(2, 2);
    run_trace(0, 1'b0);

    // program writes during FETCH and HOLD are ignored
    do_reset();
    do_start();
    prog_we   = 1'b1;
    prog_addr = 5'd3;
    prog_data = ~ref_mem[3];
    step();
    prog_addr = 5'd4;
    prog_data = ~ref_mem[4];
    step();
    prog_we   = 1'b0;
    build_trace(0, DEPTH);
    run_trace(-1, 1'b1);

    // write and start in the same cycle: fetch sees the new word
    prog_we   = 1'b1;
    prog_addr = 5'd0;
    prog_data = rand_word();
    start     = 1'b1;
    step();
    ref_mem[0] = prog_data;
    prog_we    = 1'b0;
    start      = 1'b0;
    check("wstart_busy", busy, 1);
    build_trace(0, DEPTH);
    run_trace(0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
